pwm_sample_feeder: RTL

//   Rate-matching stage directly upstream of the PWM output stage. Accepts signed

---
 rtl/pwm_sample_feeder.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pwm_sample_feeder.sv
// pwm_sample_feeder: rate-matching stage ahead of the PWM output stage.
// Accepts signed samples over valid/ready, scales and saturates them to the PWM
// data width, buffers them in a small FIFO and releases one sample per PWM frame
// (2^COUNTER_WIDTH clocks), holding it stable for the whole frame.
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   s_valid       input sample valid
//   s_data        signed input sample (IN_WIDTH)
//   s_ready       FIFO can accept a sample this cycle (registered, = !full)
//   underrun_clr  clears the sticky underrun flag
//   data_out      signed sample for the PWM, updated only on frame_tick
//   frame_tick    one-cycle pulse on the last clock of each frame
//   clip          one-cycle pulse: the previously accepted sample was saturated
//   underrun      sticky: a frame started with the FIFO empty
//   fifo_level    current FIFO occupancy, 0..FIFO_DEPTH
module pwm_sample_feeder #(
  parameter int unsigned IN_WIDTH      = 16,
  parameter int unsigned DATA_WIDTH    = 12,
  parameter int unsigned COUNTER_WIDTH = 10,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned GAIN_SHIFT    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  input  logic [IN_WIDTH-1:0]           s_data,
  output logic                          s_ready,
  input  logic                          underrun_clr,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          frame_tick,
  output logic                          clip,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned TW    = IN_WIDTH + GAIN_SHIFT;
  localparam int unsigned RSH   = IN_WIDTH - DATA_WIDTH;
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [DATA_WIDTH-1:0] SAT_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic                     tick_q, tick_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]         level_q, level_d;
  logic                     ready_q, ready_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     clip_q, clip_d;
  logic                     underrun_q, underrun_d;
  logic [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];

  logic signed [TW-1:0]     t_ext, t_scl;
  logic [TW-DATA_WIDTH:0]   t_upper;
  logic                     sat;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic                     wr_en, rd_en;

  // Gain and width reduction; saturate when the bits above the output sign
  // bit are not a pure sign extension.
  always_comb begin
    t_ext   = TW'($signed(s_data));
    t_scl   = (t_ext <<< GAIN_SHIFT) >>> RSH;
    t_upper = t_scl[TW-1:DATA_WIDTH-1];
    sat     = !((&t_upper) || !(|t_upper));
    wr_data = t_scl[DATA_WIDTH-1:0];
    if (sat) begin
      wr_data = t_scl[TW-1] ? SAT_NEG : SAT_POS;
    end
  end

  assign wr_en = s_valid && ready_q;
  assign rd_en = tick_q && (level_q != '0);

  // Next-state for counter, FIFO bookkeeping, output register and flags.
  always_comb begin
    cnt_d      = cnt_q + COUNTER_WIDTH'(1);
    // frame_tick is registered, so it is decoded from the next counter value.
    tick_d     = (cnt_d == CNT_MAX);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_d     = data_q;
    underrun_d = underrun_q;
    clip_d     = wr_en && sat;
    level_d    = level_q + LVL_W'(wr_en) - LVL_W'(rd_en);
    ready_d    = (level_d != LVL_W'(FIFO_DEPTH));
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      data_d   = mem_q[rd_ptr_q];
    end
    // Setting wins over a simultaneous clear.
    if (tick_q && (level_q == '0)) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ready_q    <= 1'b1;
      data_q     <= '0;
      clip_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ready_q    <= ready_d;
      data_q     <= data_d;
      clip_q     <= clip_d;
      underrun_q <= underrun_d;
    end
  end

  // Sample storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign s_ready    = ready_q;
  assign data_out   = data_q;
  assign frame_tick = tick_q;
  assign clip       = clip_q;
  assign underrun   = underrun_q;
  assign fifo_level = level_q;

endmodule
